// File: rtl/pipeline_interlock_pkg.sv
// Shared types for the LC-3b pipeline interlock: scoreboard entries, controller
// states and the decode-source bundle compared against the scoreboard.
package lc3b_types;

  localparam int SB_DEPTH = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;

  // One in-flight instruction's register/CC write intent.
  typedef struct packed {
    logic       valid;
    logic [2:0] dreg;
    logic       wr;
    logic       cc;
  } lc3b_sb_entry;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RAW_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } lc3b_interlock_state;

  // Everything the decode stage reads, as seen by the hazard comparators.
  typedef struct packed {
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dest;
    logic       uses_sr1;
    logic       uses_sr2;
    logic       uses_dest;
    logic       reads_cc;
  } lc3b_decode_src;

  localparam lc3b_sb_entry SB_EMPTY = '0;

  // Write flags are qualified by valid so a bubble never poisons the scoreboard.
  function automatic lc3b_sb_entry make_entry(
    input logic       valid,
    input logic [2:0] wr_reg,
    input logic       writes_reg,
    input logic       sets_cc
  );
    lc3b_sb_entry e;
    e.valid = valid;
    e.dreg  = wr_reg;
    e.wr    = valid && writes_reg;
    e.cc    = valid && sets_cc;
    return e;
  endfunction

endpackage

// File: rtl/pipeline_interlock_if.sv
// Decode-side hazard inputs and pipeline-control outputs of the interlock.
interface pipeline_interlock_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 id_valid;
  logic [2:0]           id_sr1;
  logic [2:0]           id_sr2;
  logic [2:0]           id_dest;
  logic                 id_uses_sr1;
  logic                 id_uses_sr2;
  logic                 id_uses_dest;
  logic                 id_reads_cc;
  logic                 id_writes_reg;
  logic [2:0]           id_wr_reg;
  logic                 id_sets_cc;
  logic                 mem_stall;
  logic                 br_taken;

  logic                 load_pc;
  logic                 load_if_id;
  logic                 load_id_ex;
  logic                 load_ex_mem;
  logic                 load_mem_wb;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] stall_cycles;

  modport master (
    output id_valid, id_sr1, id_sr2, id_dest, id_uses_sr1, id_uses_sr2,
           id_uses_dest, id_reads_cc, id_writes_reg, id_wr_reg, id_sets_cc,
           mem_stall, br_taken,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           if_id_flush, id_ex_bubble, state, stall_cycles
  );

  modport slave (
    input  id_valid, id_sr1, id_sr2, id_dest, id_uses_sr1, id_uses_sr2,
           id_uses_dest, id_reads_cc, id_writes_reg, id_wr_reg, id_sets_cc,
           mem_stall, br_taken,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           if_id_flush, id_ex_bubble, state, stall_cycles
  );
endinterface

// File: rtl/pipeline_interlock_hazard_compare.sv
// Matches one scoreboard entry against the registers and CC read in decode.
module hazard_compare
  import lc3b_types::*;
(
  input  lc3b_sb_entry   entry,
  input  lc3b_decode_src src,
  output logic           match
);

  logic reg_match;
  logic cc_match;

  always_comb begin
    reg_match = entry.wr && ((src.uses_sr1  && (entry.dreg == src.sr1))  ||
                             (src.uses_sr2  && (entry.dreg == src.sr2))  ||
                             (src.uses_dest && (entry.dreg == src.dest)));
    cc_match  = entry.cc && src.reads_cc;
    match     = entry.valid && (reg_match || cc_match);
  end

endmodule

// File: rtl/pipeline_interlock.sv
// Stall/flush controller for the 5-stage LC-3b pipeline without forwarding:
// scoreboard of EX/MEM/WB writes, priority sequencing and a stall counter.
module pipeline_interlock
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_interlock_if.slave  bus
);

  lc3b_sb_entry        sb_reg  [SB_DEPTH];
  lc3b_sb_entry        sb_next [SB_DEPTH];
  lc3b_interlock_state state_reg;
  lc3b_interlock_state state_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;

  lc3b_decode_src      dec_src;
  lc3b_sb_entry        id_entry;
  logic [SB_DEPTH-1:0] hit;
  logic                raw_hit;

  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic if_id_flush, id_ex_bubble;

  assign dec_src = '{
    sr1:       bus.id_sr1,
    sr2:       bus.id_sr2,
    dest:      bus.id_dest,
    uses_sr1:  bus.id_uses_sr1,
    uses_sr2:  bus.id_uses_sr2,
    uses_dest: bus.id_uses_dest,
    reads_cc:  bus.id_reads_cc
  };

  assign id_entry = make_entry(bus.id_valid, bus.id_wr_reg,
                               bus.id_writes_reg, bus.id_sets_cc);

  // WB is included: the regfile writes on the edge that decode would need it.
  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_cmp
      hazard_compare u_cmp (
        .entry (sb_reg[gi]),
        .src   (dec_src),
        .match (hit[gi])
      );
    end
  endgenerate

  assign raw_hit = bus.id_valid && (|hit);

  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_next   = RUN;
    sb_next[SB_EX]  = id_entry;
    sb_next[SB_MEM] = sb_reg[SB_EX];
    sb_next[SB_WB]  = sb_reg[SB_MEM];

    if (reset) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (bus.mem_stall) begin
      // Whole pipe freezes; branch and RAW decisions are re-made on release.
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      sb_next[SB_EX]  = sb_reg[SB_EX];
      sb_next[SB_MEM] = sb_reg[SB_MEM];
      sb_next[SB_WB]  = sb_reg[SB_WB];
      state_next   = MEM_WAIT;
    end else if (bus.br_taken) begin
      // The wrong-path instruction leaving EX never reaches MEM.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      sb_next[SB_EX]  = SB_EMPTY;
      sb_next[SB_MEM] = SB_EMPTY;
    end else if (raw_hit) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      id_ex_bubble = 1'b1;
      sb_next[SB_EX] = SB_EMPTY;
      state_next   = RAW_WAIT;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (!reset && !load_if_id && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_sb
      always_ff @(posedge clk) begin
        if (reset) begin
          sb_reg[gi] <= SB_EMPTY;
        end else begin
          sb_reg[gi] <= sb_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.load_pc      = load_pc;
  assign bus.load_if_id   = load_if_id;
  assign bus.load_id_ex   = load_id_ex;
  assign bus.load_ex_mem  = load_ex_mem;
  assign bus.load_mem_wb  = load_mem_wb;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.state        = state_reg;
  assign bus.stall_cycles = cnt_reg;

endmodule

// File: tb/tb_pipeline_interlock.sv
// Directed scoreboard bench for pipeline_interlock: each driven cycle queues its
// hand-computed control outputs; a negedge monitor pops and compares.
module tb_pipeline_interlock;

  localparam int CW = 16;

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, if_id_flush, id_ex_bubble}
  localparam logic [6:0] O_RUN   = 7'b11111_0_0;
  localparam logic [6:0] O_STALL = 7'b00111_0_1;
  localparam logic [6:0] O_MEM   = 7'b00000_0_0;
  localparam logic [6:0] O_BR    = 7'b11111_1_1;
  localparam logic [6:0] O_RST   = 7'b00000_1_1;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_RAW = 2'd1;
  localparam logic [1:0] S_MEM = 2'd2;

  typedef struct {
    logic [6:0]    ctl;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [6:0] mon_ctl;

  pipeline_interlock_if #(.CNT_WIDTH(CW)) bus_if ();

  pipeline_interlock #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_ctl = {bus_if.load_pc, bus_if.load_if_id, bus_if.load_id_ex,
                 bus_if.load_ex_mem, bus_if.load_mem_wb,
                 bus_if.if_id_flush, bus_if.id_ex_bubble};
      checks++;
      if (mon_ctl !== mon_e.ctl || bus_if.state !== mon_e.st ||
          bus_if.stall_cycles !== mon_e.cnt) begin
        failures++;
        $display("FAIL %s: ctl=%b state=%0d cnt=%h required ctl=%b state=%0d cnt=%h",
                 mon_e.name, mon_ctl, bus_if.state, bus_if.stall_cycles,
                 mon_e.ctl, mon_e.st, mon_e.cnt);
      end else begin
        $display("ok   %s: ctl=%b state=%0d cnt=%h", mon_e.name, mon_ctl,
                 bus_if.state, bus_if.stall_cycles);
      end
    end
  end

  task automatic set_dec(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] d, input logic u1, input logic u2,
                         input logic ud, input logic rcc, input logic [2:0] wreg,
                         input logic wr, input logic scc);
    bus_if.id_valid      = v;
    bus_if.id_sr1        = s1;
    bus_if.id_sr2        = s2;
    bus_if.id_dest       = d;
    bus_if.id_uses_sr1   = u1;
    bus_if.id_uses_sr2   = u2;
    bus_if.id_uses_dest  = ud;
    bus_if.id_reads_cc   = rcc;
    bus_if.id_wr_reg     = wreg;
    bus_if.id_writes_reg = wr;
    bus_if.id_sets_cc    = scc;
  endtask

  task automatic dec_nop();
    set_dec(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // ADD dr, s1, s2 (register mode, sets CC)
  task automatic dec_add(input logic [2:0] dr, input logic [2:0] s1, input logic [2:0] s2);
    set_dec(1'b1, s1, s2, dr, 1'b1, 1'b1, 1'b0, 1'b0, dr, 1'b1, 1'b1);
  endtask

  // STR src, base, #0
  task automatic dec_str(input logic [2:0] src, input logic [2:0] base);
    set_dec(1'b1, base, 3'd0, src, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic dec_br();
    set_dec(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
  endtask

  // LEA writes a register but leaves NZP alone
  task automatic dec_lea(input logic [2:0] dr);
    set_dec(1'b1, 3'd0, 3'd0, dr, 1'b0, 1'b0, 1'b0, 1'b0, dr, 1'b1, 1'b0);
  endtask

  task automatic step(input logic ms, input logic br, input logic rst,
                      input logic [6:0] ctl, input logic [1:0] st,
                      input logic [CW-1:0] cnt, input string nm);
    exp_t e;
    reset            = rst;
    bus_if.mem_stall = ms;
    bus_if.br_taken  = br;
    e.ctl = ctl; e.st = st; e.cnt = cnt; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [CW-1:0] cnt);
    dec_nop();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, O_RUN, S_RUN, cnt, "drain");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus_if.mem_stall = 1'b0;
    bus_if.br_taken  = 1'b0;
    dec_nop();
    @(posedge clk); #1;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b1, O_RST, S_RUN, 16'd0, "reset_hold");

    // ADD R1,R2,R3 ; ADD R4,R1,R5 -> three-cycle RAW stall
    dec_add(3'd1, 3'd2, 3'd3); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd0, "raw3_add1");
    dec_add(3'd4, 3'd1, 3'd5); step(1'b0, 1'b0, 1'b0, O_STALL, S_RUN, 16'd0, "raw3_ex");
    step(1'b0, 1'b0, 1'b0, O_STALL, S_RAW, 16'd1, "raw3_mem");
    step(1'b0, 1'b0, 1'b0, O_STALL, S_RAW, 16'd2, "raw3_wb");
    step(1'b0, 1'b0, 1'b0, O_RUN,   S_RAW, 16'd3, "raw3_issue");
    drain(16'd3);

    // ADD R1 ; two independent ; STR R1,R6 -> one WB-match stall
    dec_add(3'd1, 3'd2, 3'd3); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd3, "str_add1");
    dec_add(3'd2, 3'd3, 3'd4); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd3, "str_ind1");
    dec_add(3'd3, 3'd4, 3'd5); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd3, "str_ind2");
    dec_str(3'd1, 3'd6);       step(1'b0, 1'b0, 1'b0, O_STALL, S_RUN, 16'd3, "str_wb_hit");
    step(1'b0, 1'b0, 1'b0, O_RUN, S_RAW, 16'd4, "str_issue");
    drain(16'd4);

    // ADD (sets CC) ; BRz -> three-cycle CC stall
    dec_add(3'd1, 3'd2, 3'd3); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd4, "cc_add");
    dec_br();                  step(1'b0, 1'b0, 1'b0, O_STALL, S_RUN, 16'd4, "cc_ex");
    step(1'b0, 1'b0, 1'b0, O_STALL, S_RAW, 16'd5, "cc_mem");
    step(1'b0, 1'b0, 1'b0, O_STALL, S_RAW, 16'd6, "cc_wb");
    step(1'b0, 1'b0, 1'b0, O_RUN,   S_RAW, 16'd7, "cc_issue");
    drain(16'd7);

    // LEA (no CC write) ; BRz -> no stall
    dec_lea(3'd1); step(1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 16'd7, "lea");
    dec_br();      step(1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 16'd7, "lea_br_nostall");
    drain(16'd7);

    // Branch taken while decode has a RAW hit: EX/MEM squashed, MEM moves to WB
    dec_add(3'd2, 3'd5, 3'd6); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd7, "br_add2");
    dec_add(3'd1, 3'd5, 3'd6); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd7, "br_add1");
    dec_add(3'd4, 3'd1, 3'd2); step(1'b0, 1'b1, 1'b0, O_BR,    S_RUN, 16'd7, "br_flush");
    step(1'b0, 1'b0, 1'b0, O_STALL, S_RUN, 16'd7, "br_wb_only_hit");
    step(1'b0, 1'b0, 1'b0, O_RUN,   S_RAW, 16'd8, "br_issue");
    drain(16'd8);

    // mem_stall for 4 cycles in the middle of a RAW stall
    dec_add(3'd1, 3'd2, 3'd3); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd8,  "ms_add1");
    dec_add(3'd4, 3'd1, 3'd5); step(1'b0, 1'b0, 1'b0, O_STALL, S_RUN, 16'd8,  "ms_raw_ex");
    step(1'b1, 1'b0, 1'b0, O_MEM, S_RAW, 16'd9,  "ms_freeze0");
    step(1'b1, 1'b0, 1'b0, O_MEM, S_MEM, 16'd10, "ms_freeze1");
    step(1'b1, 1'b0, 1'b0, O_MEM, S_MEM, 16'd11, "ms_freeze2");
    step(1'b1, 1'b0, 1'b0, O_MEM, S_MEM, 16'd12, "ms_freeze3");
    step(1'b0, 1'b0, 1'b0, O_STALL, S_MEM, 16'd13, "ms_resume_mem");
    step(1'b0, 1'b0, 1'b0, O_STALL, S_RAW, 16'd14, "ms_resume_wb");
    step(1'b0, 1'b0, 1'b0, O_RUN,   S_RAW, 16'd15, "ms_issue");
    drain(16'd15);

    // Reset in RAW_WAIT clears scoreboard, state and counter
    dec_add(3'd1, 3'd2, 3'd3); step(1'b0, 1'b0, 1'b0, O_RUN,   S_RUN, 16'd15, "rst_add1");
    dec_add(3'd4, 3'd1, 3'd5); step(1'b0, 1'b0, 1'b0, O_STALL, S_RUN, 16'd15, "rst_raw");
    step(1'b0, 1'b0, 1'b1, O_RST, S_RAW, 16'd16, "rst_mid_raw");
    step(1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 16'd0,  "rst_after_nostall");
    drain(16'd0);

    // Saturation: 65534 unchecked stalled cycles, then watch the top
    dec_nop();
    bus_if.mem_stall = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, O_MEM, S_MEM, 16'hFFFE, "sat_fffe");
    step(1'b1, 1'b0, 1'b0, O_MEM, S_MEM, 16'hFFFF, "sat_ffff");
    step(1'b1, 1'b0, 1'b0, O_MEM, S_MEM, 16'hFFFF, "sat_hold");
    step(1'b0, 1'b0, 1'b0, O_RUN, S_MEM, 16'hFFFF, "sat_release");
    step(1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 16'hFFFF, "sat_run");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_queue: pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
